cabac_decode_bin_core: RTL and testbench

//  HEVC (H.265 9.3.4.3.2) CABAC regular-bin decode engine: one context-coded bin per evaluation.

---
 rtl/cabac_pkg.sv | 62 ++++++
 rtl/cabac_renorm.sv | 41 ++++
 rtl/cabac_decode_bin_core.sv | 123 ++++++++++++
 tb/tb_cabac_decode_bin_core.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cabac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : cabac_pkg                                                   |
// | Description: HEVC CABAC regular-bin constants: LPS range table, LPS      |
// |              state transition table, state/range limits.                 |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package cabac_pkg;

   localparam logic [5:0] MAX_PSTATE = 6'd62;
   localparam logic [8:0] RANGE_MIN  = 9'd256;

   // rangeTabLps indexed [pStateIdx][qRangeIdx]
   localparam logic [7:0] RANGE_TAB_LPS [0:63][0:3] = '{
      '{8'd128, 8'd176, 8'd208, 8'd240}, '{8'd128, 8'd167, 8'd197, 8'd227},
      '{8'd128, 8'd158, 8'd187, 8'd216}, '{8'd123, 8'd150, 8'd178, 8'd205},
      '{8'd116, 8'd142, 8'd169, 8'd195}, '{8'd111, 8'd135, 8'd160, 8'd185},
      '{8'd105, 8'd128, 8'd152, 8'd175}, '{8'd100, 8'd122, 8'd144, 8'd166},
      '{8'd95,  8'd116, 8'd137, 8'd158}, '{8'd90,  8'd110, 8'd130, 8'd150},
      '{8'd85,  8'd104, 8'd123, 8'd142}, '{8'd81,  8'd99,  8'd117, 8'd135},
      '{8'd77,  8'd94,  8'd111, 8'd128}, '{8'd73,  8'd89,  8'd105, 8'd122},
      '{8'd69,  8'd85,  8'd100, 8'd116}, '{8'd66,  8'd80,  8'd95,  8'd110},
      '{8'd62,  8'd76,  8'd90,  8'd104}, '{8'd59,  8'd72,  8'd86,  8'd99},
      '{8'd56,  8'd69,  8'd81,  8'd94},  '{8'd53,  8'd65,  8'd77,  8'd89},
      '{8'd51,  8'd62,  8'd73,  8'd85},  '{8'd48,  8'd59,  8'd69,  8'd80},
      '{8'd46,  8'd56,  8'd66,  8'd76},  '{8'd43,  8'd53,  8'd63,  8'd72},
      '{8'd41,  8'd50,  8'd59,  8'd69},  '{8'd39,  8'd48,  8'd56,  8'd65},
      '{8'd37,  8'd45,  8'd54,  8'd62},  '{8'd35,  8'd43,  8'd51,  8'd59},
      '{8'd33,  8'd41,  8'd48,  8'd56},  '{8'd32,  8'd39,  8'd46,  8'd53},
      '{8'd30,  8'd37,  8'd43,  8'd50},  '{8'd29,  8'd35,  8'd41,  8'd48},
      '{8'd27,  8'd33,  8'd39,  8'd45},  '{8'd26,  8'd31,  8'd37,  8'd43},
      '{8'd24,  8'd30,  8'd35,  8'd41},  '{8'd23,  8'd28,  8'd33,  8'd39},
      '{8'd22,  8'd27,  8'd32,  8'd37},  '{8'd21,  8'd26,  8'd30,  8'd35},
      '{8'd20,  8'd24,  8'd29,  8'd33},  '{8'd19,  8'd23,  8'd27,  8'd31},
      '{8'd18,  8'd22,  8'd26,  8'd30},  '{8'd17,  8'd21,  8'd25,  8'd28},
      '{8'd16,  8'd20,  8'd23,  8'd27},  '{8'd15,  8'd19,  8'd22,  8'd25},
      '{8'd14,  8'd18,  8'd21,  8'd24},  '{8'd14,  8'd17,  8'd20,  8'd23},
      '{8'd13,  8'd16,  8'd19,  8'd22},  '{8'd12,  8'd15,  8'd18,  8'd21},
      '{8'd12,  8'd14,  8'd17,  8'd20},  '{8'd11,  8'd14,  8'd16,  8'd19},
      '{8'd11,  8'd13,  8'd15,  8'd18},  '{8'd10,  8'd12,  8'd15,  8'd17},
      '{8'd10,  8'd12,  8'd14,  8'd16},  '{8'd9,   8'd11,  8'd13,  8'd15},
      '{8'd9,   8'd11,  8'd12,  8'd14},  '{8'd8,   8'd10,  8'd12,  8'd14},
      '{8'd8,   8'd9,   8'd11,  8'd13},  '{8'd7,   8'd9,   8'd11,  8'd12},
      '{8'd7,   8'd9,   8'd10,  8'd12},  '{8'd7,   8'd8,   8'd10,  8'd11},
      '{8'd6,   8'd8,   8'd9,   8'd11},  '{8'd6,   8'd7,   8'd9,   8'd10},
      '{8'd6,   8'd7,   8'd8,   8'd9},   '{8'd2,   8'd2,   8'd2,   8'd2}
   };

   // transIdxLps indexed [pStateIdx]
   localparam logic [5:0] TRANS_IDX_LPS [0:63] = '{
      6'd0,  6'd0,  6'd1,  6'd2,  6'd2,  6'd4,  6'd4,  6'd5,
      6'd6,  6'd7,  6'd8,  6'd9,  6'd9,  6'd11, 6'd11, 6'd12,
      6'd13, 6'd13, 6'd15, 6'd15, 6'd16, 6'd16, 6'd18, 6'd18,
      6'd19, 6'd19, 6'd21, 6'd21, 6'd22, 6'd22, 6'd23, 6'd24,
      6'd24, 6'd25, 6'd26, 6'd26, 6'd27, 6'd27, 6'd28, 6'd29,
      6'd29, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd32, 6'd33,
      6'd33, 6'd33, 6'd34, 6'd34, 6'd35, 6'd35, 6'd35, 6'd36,
      6'd36, 6'd36, 6'd37, 6'd37, 6'd37, 6'd38, 6'd38, 6'd63
   };

endpackage : cabac_pkg
`default_nettype wire

// File: rtl/cabac_renorm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : cabac_renorm                                                |
// | Description: CABAC renormalisation. Counts leading zeros of the 9-bit    |
// |              range (clamped to 6), shifts range and offset left by that  |
// |              count and fills the offset LSBs from the look-ahead bits.   |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module cabac_renorm
   import cabac_pkg::*;
(
   input  logic [8:0] i_range,
   input  logic [8:0] i_offset,
   input  logic [5:0] i_rbsp,
   output logic [8:0] o_range,
   output logic [8:0] o_offset,
   output logic [2:0] o_len
);

   logic [2:0] w_len;

   // Leading-zero count; anything needing more than 6 shifts saturates at 6
   always_comb begin
      w_len = 3'd6;
      if (i_range >= RANGE_MIN) w_len = 3'd0;
      else if (i_range[7])      w_len = 3'd1;
      else if (i_range[6])      w_len = 3'd2;
      else if (i_range[5])      w_len = 3'd3;
      else if (i_range[4])      w_len = 3'd4;
      else if (i_range[3])      w_len = 3'd5;
   end

   // Bit 5 of the look-ahead is the first bit shifted into the offset
   always_comb begin
      o_len    = w_len;
      o_range  = i_range << w_len;
      o_offset = (i_offset << w_len) | ({3'b000, i_rbsp} >> (3'd6 - w_len));
   end

endmodule : cabac_renorm
`default_nettype wire

// File: rtl/cabac_decode_bin_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : cabac_decode_bin_core                                       |
// | Description: HEVC CABAC regular (context-coded) bin decode: LPS table    |
// |              lookup, MPS/LPS decision, context update, renormalisation.  |
// |              Macro CABAC_DECODE_BIN_REG_OUT_EN registers all outputs     |
// |              (1-cycle latency); otherwise the block is combinational.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module cabac_decode_bin_core
   import cabac_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] i_ivlCurrRange,
   input  logic [8:0] i_ivlOffset,
   input  logic [5:0] i_pStateIdx,
   input  logic       i_valMps,
   input  logic [5:0] i_rbsp_in,
   output logic [8:0] o_ivlCurrRange,
   output logic [8:0] o_ivlOffset,
   output logic [5:0] o_pStateIdx,
   output logic       o_valMps,
   output logic       o_binVal,
   output logic [2:0] o_output_len
);

   logic [5:0] w_pst_idx;
   logic [1:0] w_q_idx;
   logic [8:0] w_rlps;
   logic [8:0] w_rmps;
   logic       w_is_lps;
   logic [8:0] w_rng_pre;
   logic [8:0] w_off_pre;
   logic [5:0] w_pst_nxt;
   logic       w_mps_nxt;
   logic       w_bin;
   logic [8:0] w_rng_out;
   logic [8:0] w_off_out;
   logic [2:0] w_len;

   // State 63 is not a legal context state; decode it as 62
   assign w_pst_idx = (i_pStateIdx > MAX_PSTATE) ? MAX_PSTATE : i_pStateIdx;
   assign w_q_idx   = i_ivlCurrRange[7:6];
   assign w_rlps    = {1'b0, RANGE_TAB_LPS[w_pst_idx][w_q_idx]};
   assign w_rmps    = i_ivlCurrRange - w_rlps;
   assign w_is_lps  = (i_ivlOffset >= w_rmps);

   // MPS/LPS decision and context state transition
   always_comb begin
      w_bin     = i_valMps;
      w_rng_pre = w_rmps;
      w_off_pre = i_ivlOffset;
      w_mps_nxt = i_valMps;
      w_pst_nxt = (w_pst_idx == MAX_PSTATE) ? MAX_PSTATE : w_pst_idx + 6'd1;
      if (w_is_lps) begin
         w_bin     = ~i_valMps;
         w_rng_pre = w_rlps;
         w_off_pre = i_ivlOffset - w_rmps;
         w_pst_nxt = TRANS_IDX_LPS[w_pst_idx];
         if (w_pst_idx == 6'd0) begin
            w_mps_nxt = ~i_valMps;
         end
      end
   end

   cabac_renorm u_renorm (
      .i_range  (w_rng_pre),
      .i_offset (w_off_pre),
      .i_rbsp   (i_rbsp_in),
      .o_range  (w_rng_out),
      .o_offset (w_off_out),
      .o_len    (w_len)
   );

`ifdef CABAC_DECODE_BIN_REG_OUT_EN
   logic [8:0] r_rng;
   logic [8:0] r_off;
   logic [5:0] r_pst;
   logic       r_mps;
   logic       r_bin;
   logic [2:0] r_len;

   // Output register; reset drops any in-flight result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rng <= 9'd510;
         r_off <= 9'd0;
         r_pst <= 6'd0;
         r_mps <= 1'b0;
         r_bin <= 1'b0;
         r_len <= 3'd0;
      end else begin
         r_rng <= w_rng_out;
         r_off <= w_off_out;
         r_pst <= w_pst_nxt;
         r_mps <= w_mps_nxt;
         r_bin <= w_bin;
         r_len <= w_len;
      end
   end

   assign o_ivlCurrRange = r_rng;
   assign o_ivlOffset    = r_off;
   assign o_pStateIdx    = r_pst;
   assign o_valMps       = r_mps;
   assign o_binVal       = r_bin;
   assign o_output_len   = r_len;
`else
   // Zero-latency build: clock and reset are not used
   logic w_unused_clk_rst;
   assign w_unused_clk_rst = clk ^ rst;

   assign o_ivlCurrRange = w_rng_out;
   assign o_ivlOffset    = w_off_out;
   assign o_pStateIdx    = w_pst_nxt;
   assign o_valMps       = w_mps_nxt;
   assign o_binVal       = w_bin;
   assign o_output_len   = w_len;
`endif

endmodule : cabac_decode_bin_core
`default_nettype wire

// File: tb/tb_cabac_decode_bin_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_cabac_decode_bin_core                                    |
// | Description: Self-checking bench for cabac_decode_bin_core: directed     |
// |              vector table, reset sequence (registered build), and random |
// |              legal inputs against a bit-serial reference model.         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_cabac_decode_bin_core;

   logic       clk;
   logic       rst;
   logic [8:0] i_ivlCurrRange;
   logic [8:0] i_ivlOffset;
   logic [5:0] i_pStateIdx;
   logic       i_valMps;
   logic [5:0] i_rbsp_in;
   logic [8:0] o_ivlCurrRange;
   logic [8:0] o_ivlOffset;
   logic [5:0] o_pStateIdx;
   logic       o_valMps;
   logic       o_binVal;
   logic [2:0] o_output_len;

   int n_pass;
   int n_total;

   cabac_decode_bin_core dut (
      .clk            (clk),
      .rst            (rst),
      .i_ivlCurrRange (i_ivlCurrRange),
      .i_ivlOffset    (i_ivlOffset),
      .i_pStateIdx    (i_pStateIdx),
      .i_valMps       (i_valMps),
      .i_rbsp_in      (i_rbsp_in),
      .o_ivlCurrRange (o_ivlCurrRange),
      .o_ivlOffset    (o_ivlOffset),
      .o_pStateIdx    (o_pStateIdx),
      .o_valMps       (o_valMps),
      .o_binVal       (o_binVal),
      .o_output_len   (o_output_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent copy of the standard's LPS range table, row = pStateIdx
   int tab_lps [64][4] = '{
      '{128,176,208,240}, '{128,167,197,227}, '{128,158,187,216}, '{123,150,178,205},
      '{116,142,169,195}, '{111,135,160,185}, '{105,128,152,175}, '{100,122,144,166},
      '{95,116,137,158},  '{90,110,130,150},  '{85,104,123,142},  '{81,99,117,135},
      '{77,94,111,128},   '{73,89,105,122},   '{69,85,100,116},   '{66,80,95,110},
      '{62,76,90,104},    '{59,72,86,99},     '{56,69,81,94},     '{53,65,77,89},
      '{51,62,73,85},     '{48,59,69,80},     '{46,56,66,76},     '{43,53,63,72},
      '{41,50,59,69},     '{39,48,56,65},     '{37,45,54,62},     '{35,43,51,59},
      '{33,41,48,56},     '{32,39,46,53},     '{30,37,43,50},     '{29,35,41,48},
      '{27,33,39,45},     '{26,31,37,43},     '{24,30,35,41},     '{23,28,33,39},
      '{22,27,32,37},     '{21,26,30,35},     '{20,24,29,33},     '{19,23,27,31},
      '{18,22,26,30},     '{17,21,25,28},     '{16,20,23,27},     '{15,19,22,25},
      '{14,18,21,24},     '{14,17,20,23},     '{13,16,19,22},     '{12,15,18,21},
      '{12,14,17,20},     '{11,14,16,19},     '{11,13,15,18},     '{10,12,15,17},
      '{10,12,14,16},     '{9,11,13,15},      '{9,11,12,14},      '{8,10,12,14},
      '{8,9,11,13},       '{7,9,11,12},       '{7,9,10,12},       '{7,8,10,11},
      '{6,8,9,11},        '{6,7,9,10},        '{6,7,8,9},         '{2,2,2,2}
   };

   int tab_trans [64] = '{
      0,0,1,2,2,4,4,5,       6,7,8,9,9,11,11,12,
      13,13,15,15,16,16,18,18, 19,19,21,21,22,22,23,24,
      24,25,26,26,27,27,28,29, 29,30,30,30,31,32,32,33,
      33,33,34,34,35,35,35,36, 36,36,37,37,37,38,38,63
   };

   typedef struct {
      int rng; int off; int pst; int mps; int rbsp;
      int e_rng; int e_off; int e_pst; int e_mps; int e_bin; int e_len;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
   endtask

   // Drive at the falling edge, sample 1 time unit after the next rising edge;
   // valid for both the combinational and the registered build
   task automatic apply(input int rng, input int off, input int pst, input int mps,
                        input int rbsp, input logic rst_v);
      @(negedge clk);
      rst            = rst_v;
      i_ivlCurrRange = rng[8:0];
      i_ivlOffset    = off[8:0];
      i_pStateIdx    = pst[5:0];
      i_valMps       = mps[0];
      i_rbsp_in      = rbsp[5:0];
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int e_rng, input int e_off, input int e_pst,
                            input int e_mps, input int e_bin, input int e_len);
      chk({tag, ".rng"}, 16'(o_ivlCurrRange), 16'(e_rng));
      chk({tag, ".off"}, 16'(o_ivlOffset),    16'(e_off));
      chk({tag, ".pst"}, 16'(o_pStateIdx),    16'(e_pst));
      chk({tag, ".mps"}, 16'(o_valMps),       16'(e_mps));
      chk({tag, ".bin"}, 16'(o_binVal),       16'(e_bin));
      chk({tag, ".len"}, 16'(o_output_len),   16'(e_len));
   endtask

   // Reference: arithmetic decode, then renormalise one bit at a time
   task automatic model(input int rng, input int off, input int pst, input int mps, input int rbsp,
                        output int e_rng, output int e_off, output int e_pst,
                        output int e_mps, output int e_bin, output int e_len);
      int p, rlps, rmps, r, o, n;
      p    = (pst > 62) ? 62 : pst;
      rlps = tab_lps[p][(rng / 64) % 4];
      rmps = rng - rlps;
      if (off >= rmps) begin
         e_bin = 1 - mps;
         o     = off - rmps;
         r     = rlps;
         e_mps = (p == 0) ? 1 - mps : mps;
         e_pst = tab_trans[p];
      end else begin
         e_bin = mps;
         o     = off;
         r     = rmps;
         e_mps = mps;
         e_pst = (p + 1 > 62) ? 62 : p + 1;
      end
      n = 0;
      while (r < 256 && n < 6) begin
         r = r * 2;
         o = o * 2 + ((rbsp >> (5 - n)) & 1);
         n++;
      end
      e_rng = r % 512;
      e_off = o % 512;
      e_len = n;
   endtask

   initial begin
      int r, o, p, m, b;
      int er, eo, ep, em, eb, el;
      n_pass  = 0;
      n_total = 0;

      //            rng  off  pst mps rbsp    e_rng e_off e_pst e_mps e_bin e_len
      vecs[0] = '{510,   0,   0, 0, 6'b000000, 270,   0,   1, 0, 0, 0};
      vecs[1] = '{510, 300,   0, 0, 6'b100000, 480,  61,   0, 1, 1, 1};
      vecs[2] = '{256, 255,  62, 0, 6'b101010, 384, 362,  38, 0, 1, 6};
      vecs[3] = '{256,  10,   0, 1, 6'b100000, 256,  21,   1, 1, 1, 1};
      vecs[4] = '{300,   0,  62, 1, 6'b000000, 294,   0,  62, 1, 1, 0};
      // offset exactly equal to rMps (270) takes the LPS path
      vecs[5] = '{510, 270,   0, 0, 6'b100000, 480,   1,   0, 1, 1, 1};
      // offset one below rMps stays on the MPS path
      vecs[6] = '{510, 269,   0, 1, 6'b111111, 270, 269,   1, 1, 1, 0};
      // pState 63 behaves as 62
      vecs[7] = '{300,   0,  63, 1, 6'b000000, 294,   0,  62, 1, 1, 0};

      rst            = 1'b1;
      i_ivlCurrRange = 9'd510;
      i_ivlOffset    = 9'd0;
      i_pStateIdx    = 6'd0;
      i_valMps       = 1'b0;
      i_rbsp_in      = 6'd0;

`ifdef CABAC_DECODE_BIN_REG_OUT_EN
      apply(510, 300, 0, 0, 6'b100000, 1'b1);
      check_all("reset", 510, 0, 0, 0, 0, 0);
`else
      apply(510, 300, 0, 0, 6'b100000, 1'b1);
`endif

      for (int i = 0; i < 8; i++) begin
         apply(vecs[i].rng, vecs[i].off, vecs[i].pst, vecs[i].mps, vecs[i].rbsp, 1'b0);
         check_all($sformatf("vec%0d", i), vecs[i].e_rng, vecs[i].e_off, vecs[i].e_pst,
                   vecs[i].e_mps, vecs[i].e_bin, vecs[i].e_len);
      end

`ifdef CABAC_DECODE_BIN_REG_OUT_EN
      // Reset while a result is in flight, then a fresh vector one cycle later
      apply(vecs[2].rng, vecs[2].off, vecs[2].pst, vecs[2].mps, vecs[2].rbsp, 1'b1);
      check_all("midrst", 510, 0, 0, 0, 0, 0);
      apply(vecs[0].rng, vecs[0].off, vecs[0].pst, vecs[0].mps, vecs[0].rbsp, 1'b0);
      check_all("postrst", vecs[0].e_rng, vecs[0].e_off, vecs[0].e_pst,
                vecs[0].e_mps, vecs[0].e_bin, vecs[0].e_len);
      // Back-to-back results, one per cycle
      apply(vecs[2].rng, vecs[2].off, vecs[2].pst, vecs[2].mps, vecs[2].rbsp, 1'b0);
      check_all("b2b", vecs[2].e_rng, vecs[2].e_off, vecs[2].e_pst,
                vecs[2].e_mps, vecs[2].e_bin, vecs[2].e_len);
`endif

      for (int k = 0; k < 400; k++) begin
         r = 256 + $urandom_range(254);
         // bias some offsets toward the MPS/LPS boundary region
         o = (k % 4 == 0) ? r - 1 - $urandom_range(20) : $urandom_range(r - 1);
         p = $urandom_range(62);
         m = $urandom_range(1);
         b = $urandom_range(63);
         model(r, o, p, m, b, er, eo, ep, em, eb, el);
         apply(r, o, p, m, b, 1'b0);
         check_all($sformatf("rnd%0d", k), er, eo, ep, em, eb, el);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_cabac_decode_bin_core
`default_nettype wire
